// File: rtl/alu_arbiter_if.sv
// Bundle of request, ALU and response signals shared by alu_arbiter and its users.
// With ALU_ARB_STATS_EN defined the bundle also carries the grant counters and
// their synchronous clear.
interface alu_arbiter_if #(parameter int DATA_W = 16);
    logic              a_valid;
    logic              a_ready;
    logic [DATA_W-1:0] a_x;
    logic [DATA_W-1:0] a_y;
    logic              b_valid;
    logic              b_ready;
    logic [DATA_W-1:0] b_x;
    logic [DATA_W-1:0] b_y;
    logic [DATA_W-1:0] alu_x;
    logic [DATA_W-1:0] alu_y;
    logic [DATA_W-1:0] alu_z;
    logic              alu_cy;
    logic              alu_s;
    logic              alu_zr;
    logic              alu_p;
    logic              alu_v;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_z;
    logic [4:0]        rsp_flags;
    logic              busy;
`ifdef ALU_ARB_STATS_EN
    logic [15:0]       a_grants;
    logic [15:0]       b_grants;
    logic              stats_clr;
`endif

    // Arbiter side
    modport slave (
        input  a_valid, a_x, a_y, b_valid, b_x, b_y,
        input  alu_z, alu_cy, alu_s, alu_zr, alu_p, alu_v, rsp_ready,
`ifdef ALU_ARB_STATS_EN
        input  stats_clr,
        output a_grants, b_grants,
`endif
        output a_ready, b_ready, alu_x, alu_y,
        output rsp_valid, rsp_id, rsp_z, rsp_flags, busy
    );

    // Requester / ALU / consumer side
    modport master (
        output a_valid, a_x, a_y, b_valid, b_x, b_y,
        output alu_z, alu_cy, alu_s, alu_zr, alu_p, alu_v, rsp_ready,
`ifdef ALU_ARB_STATS_EN
        output stats_clr,
        input  a_grants, b_grants,
`endif
        input  a_ready, b_ready, alu_x, alu_y,
        input  rsp_valid, rsp_id, rsp_z, rsp_flags, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one external ALU between requesters A and B.
// A granted request registers its operands onto the ALU, waits SETTLE_CYC cycles,
// then captures the result and flags into a response held until it is taken.
// Optional feature macro: ALU_ARB_STATS_EN adds per-requester grant counters.
module alu_arbiter #(
    parameter int DATA_W     = 16,
    parameter int SETTLE_CYC = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYC - 1);

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              cur_id_q, cur_id_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] alu_x_q, alu_x_d;
    logic [DATA_W-1:0] alu_y_q, alu_y_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_z_q, rsp_z_d;
    logic [4:0]        rsp_flags_q, rsp_flags_d;
    logic              grant_a;
    logic              grant_b;

    // Round-robin grant: a tie goes to whoever was not granted last time
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state_q == IDLE) begin
            if (bus.a_valid && (!bus.b_valid || last_grant_q)) begin
                grant_a = 1'b1;
            end else if (bus.b_valid) begin
                grant_b = 1'b1;
            end
        end
    end

    // Next-state logic for the IDLE -> EXEC -> RESP sequence
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cur_id_d     = cur_id_q;
        cnt_d        = cnt_q;
        alu_x_d      = alu_x_q;
        alu_y_d      = alu_y_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_z_d      = rsp_z_q;
        rsp_flags_d  = rsp_flags_q;
        case (state_q)
            IDLE: begin
                if (grant_a || grant_b) begin
                    state_d      = EXEC;
                    cnt_d        = CNT_LOAD;
                    cur_id_d     = grant_b;
                    last_grant_d = grant_b;
                    alu_x_d      = grant_b ? bus.b_x : bus.a_x;
                    alu_y_d      = grant_b ? bus.b_y : bus.a_y;
                end
            end
            EXEC: begin
                if (cnt_q == 4'd0) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = cur_id_q;
                    rsp_z_d     = bus.alu_z;
                    rsp_flags_d = {bus.alu_v, bus.alu_p, bus.alu_zr, bus.alu_s, bus.alu_cy};
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; last_grant resets to B so A wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cur_id_q     <= 1'b0;
            cnt_q        <= 4'd0;
            alu_x_q      <= '0;
            alu_y_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_z_q      <= '0;
            rsp_flags_q  <= 5'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cur_id_q     <= cur_id_d;
            cnt_q        <= cnt_d;
            alu_x_q      <= alu_x_d;
            alu_y_q      <= alu_y_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_z_q      <= rsp_z_d;
            rsp_flags_q  <= rsp_flags_d;
        end
    end

    assign bus.a_ready   = grant_a;
    assign bus.b_ready   = grant_b;
    assign bus.alu_x     = alu_x_q;
    assign bus.alu_y     = alu_y_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_z     = rsp_z_q;
    assign bus.rsp_flags = rsp_flags_q;
    assign bus.busy      = (state_q != IDLE);

`ifdef ALU_ARB_STATS_EN
    logic [15:0] a_grants_q;
    logic [15:0] b_grants_q;

    // Grant counters; a clear in the same cycle as a grant wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_grants_q <= 16'd0;
            b_grants_q <= 16'd0;
        end else if (bus.stats_clr) begin
            a_grants_q <= 16'd0;
            b_grants_q <= 16'd0;
        end else begin
            if (grant_a) a_grants_q <= a_grants_q + 16'd1;
            if (grant_b) b_grants_q <= b_grants_q + 16'd1;
        end
    end

    assign bus.a_grants = a_grants_q;
    assign bus.b_grants = b_grants_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: one instance with SETTLE_CYC=1 behind a bench adder,
// one with SETTLE_CYC=4 behind a bench-controlled ALU output.
module tb_alu_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   fails = 0;

    alu_arbiter_if #(.DATA_W(16)) bus1 ();
    alu_arbiter_if #(.DATA_W(16)) bus4 ();

    alu_arbiter #(.DATA_W(16), .SETTLE_CYC(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    alu_arbiter #(.DATA_W(16), .SETTLE_CYC(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    always #5 clk = ~clk;

    // Bench ALU for dut1: 16-bit adder with flags
    logic [16:0] alu1Sum;
    assign alu1Sum      = {1'b0, bus1.alu_x} + {1'b0, bus1.alu_y};
    assign bus1.alu_z   = alu1Sum[15:0];
    assign bus1.alu_cy  = alu1Sum[16];
    assign bus1.alu_s   = alu1Sum[15];
    assign bus1.alu_zr  = (alu1Sum[15:0] == 16'd0);
    assign bus1.alu_p   = ~^alu1Sum[15:0];
    assign bus1.alu_v   = (bus1.alu_x[15] == bus1.alu_y[15]) && (alu1Sum[15] != bus1.alu_x[15]);

    // Bench ALU for dut4: outputs set directly by the stimulus
    logic [15:0] alu4Z = 16'd0;
    logic [4:0]  alu4Flags = 5'd0;
    assign bus4.alu_z = alu4Z;
    assign {bus4.alu_v, bus4.alu_p, bus4.alu_zr, bus4.alu_s, bus4.alu_cy} = alu4Flags;

    // Reference result of an addition: {V,P,ZR,S,CY, Z} from integer arithmetic
    function automatic logic [20:0] refAdd(input logic [15:0] x, input logic [15:0] y);
        int ux, uy, sum, zi, sx, sy, ssum;
        logic cy, s, zr, p, v;
        ux = int'(x);
        uy = int'(y);
        sum = ux + uy;
        zi = sum % 65536;
        cy = (sum > 65535);
        s = (zi >= 32768);
        zr = (zi == 0);
        p = (($countones(16'(zi)) % 2) == 0);
        sx = (ux >= 32768) ? ux - 65536 : ux;
        sy = (uy >= 32768) ? uy - 65536 : uy;
        ssum = sx + sy;
        v = (ssum > 32767) || (ssum < -32768);
        return {v, p, zr, s, cy, 16'(zi)};
    endfunction

    task automatic idleInputs();
        bus1.a_valid = 1'b0; bus1.b_valid = 1'b0; bus1.rsp_ready = 1'b0;
        bus1.a_x = 16'd0; bus1.a_y = 16'd0; bus1.b_x = 16'd0; bus1.b_y = 16'd0;
        bus4.a_valid = 1'b0; bus4.b_valid = 1'b0; bus4.rsp_ready = 1'b0;
        bus4.a_x = 16'd0; bus4.a_y = 16'd0; bus4.b_x = 16'd0; bus4.b_y = 16'd0;
`ifdef ALU_ARB_STATS_EN
        bus1.stats_clr = 1'b0;
        bus4.stats_clr = 1'b0;
`endif
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        idleInputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Wait for rsp_valid on dut1 counting edges from the current (grant) cycle
    task automatic waitResp1(input bit dropValids, output bit ok, output int edges);
        ok = 1'b0;
        edges = 0;
        while (!ok && edges < 64) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (dropValids && edges == 1) begin
                bus1.a_valid = 1'b0;
                bus1.b_valid = 1'b0;
            end
            if (bus1.rsp_valid === 1'b1) ok = 1'b1;
        end
    endtask

    // One request on dut1, consumed immediately, ending back in IDLE
    task automatic runOne1(input bit useB, input logic [15:0] x, input logic [15:0] y, output bit ok);
        int edges;
        @(negedge clk);
        if (useB) begin bus1.b_valid = 1'b1; bus1.b_x = x; bus1.b_y = y; end
        else begin bus1.a_valid = 1'b1; bus1.a_x = x; bus1.a_y = y; end
        bus1.rsp_ready = 1'b1;
        #1;
        waitResp1(1'b1, ok, edges);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idleInputs();
        repeat (2) @(negedge clk);
        checks++; if (bus1.rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_rsp_valid got %0b expected 0", bus1.rsp_valid); end
        checks++; if (bus1.rsp_z !== 16'd0) begin fails++; $display("[TB] FAIL reset_rsp_z got %h expected 0000", bus1.rsp_z); end
        checks++; if (bus1.rsp_flags !== 5'd0 || bus1.rsp_id !== 1'b0) begin fails++; $display("[TB] FAIL reset_rsp_flags_id got %b/%b expected 00000/0", bus1.rsp_flags, bus1.rsp_id); end
        checks++; if (bus1.alu_x !== 16'd0 || bus1.alu_y !== 16'd0) begin fails++; $display("[TB] FAIL reset_alu_xy got %h/%h expected 0000/0000", bus1.alu_x, bus1.alu_y); end
        checks++; if (bus1.busy !== 1'b0 || bus1.a_ready !== 1'b0 || bus1.b_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy_ready got %b%b%b expected 000", bus1.busy, bus1.a_ready, bus1.b_ready); end
`ifdef ALU_ARB_STATS_EN
        checks++; if (bus1.a_grants !== 16'd0 || bus1.b_grants !== 16'd0) begin fails++; $display("[TB] FAIL reset_grants got %0d/%0d expected 0/0", bus1.a_grants, bus1.b_grants); end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_single_a();
        bit ok;
        int edges;
        logic [20:0] exp;
        doReset();
        bus1.a_x = 16'h8fff; bus1.a_y = 16'h8000; bus1.a_valid = 1'b1; bus1.rsp_ready = 1'b1;
        exp = refAdd(16'h8fff, 16'h8000);
        #1;
        checks++; if (bus1.a_ready !== 1'b1 || bus1.b_ready !== 1'b0) begin fails++; $display("[TB] FAIL single_ready got a=%b b=%b expected a=1 b=0", bus1.a_ready, bus1.b_ready); end
        waitResp1(1'b1, ok, edges);
        checks++; if (!ok || edges != 2) begin fails++; $display("[TB] FAIL single_latency got %0d edges (ok=%0b) expected 2", edges, ok); end
        checks++; if (bus1.rsp_id !== 1'b0 || bus1.rsp_z !== 16'h0fff) begin fails++; $display("[TB] FAIL single_result got id=%b z=%h expected id=0 z=0fff", bus1.rsp_id, bus1.rsp_z); end
        checks++; if (bus1.rsp_flags !== exp[20:16] || bus1.rsp_flags[0] !== 1'b1 || bus1.rsp_flags[4] !== 1'b1) begin fails++; $display("[TB] FAIL single_flags got %b expected %b", bus1.rsp_flags, exp[20:16]); end
        @(negedge clk);
        checks++; if (bus1.rsp_valid !== 1'b0 || bus1.busy !== 1'b0) begin fails++; $display("[TB] FAIL single_retire got valid=%b busy=%b expected 0/0", bus1.rsp_valid, bus1.busy); end
        bus1.rsp_ready = 1'b0;
    endtask

    task automatic test_round_robin();
        bit ok;
        int edges;
        bit expA;
        logic [20:0] exp;
        doReset();
        bus1.a_x = 16'hfffe; bus1.a_y = 16'h8002; bus1.b_x = 16'haaaa; bus1.b_y = 16'h5555;
        bus1.a_valid = 1'b1; bus1.b_valid = 1'b1; bus1.rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            expA = (i % 2 == 0);
            exp = expA ? refAdd(16'hfffe, 16'h8002) : refAdd(16'haaaa, 16'h5555);
            checks++; if (bus1.a_ready !== expA || bus1.b_ready !== !expA) begin fails++; $display("[TB] FAIL rr_grant%0d got a=%b b=%b expected a=%b b=%b", i, bus1.a_ready, bus1.b_ready, expA, !expA); end
            waitResp1(1'b0, ok, edges);
            checks++; if (!ok || bus1.rsp_id !== !expA || bus1.rsp_z !== (expA ? 16'h8000 : 16'hffff)) begin fails++; $display("[TB] FAIL rr_result%0d got ok=%0b id=%b z=%h expected id=%b z=%h", i, ok, bus1.rsp_id, bus1.rsp_z, !expA, exp[15:0]); end
            checks++; if (bus1.rsp_flags !== exp[20:16]) begin fails++; $display("[TB] FAIL rr_flags%0d got %b expected %b", i, bus1.rsp_flags, exp[20:16]); end
            checks++; if (bus1.a_ready !== 1'b0 || bus1.b_ready !== 1'b0) begin fails++; $display("[TB] FAIL rr_ready_in_resp%0d got a=%b b=%b expected 0/0", i, bus1.a_ready, bus1.b_ready); end
            @(negedge clk);
        end
        bus1.a_valid = 1'b0; bus1.b_valid = 1'b0; bus1.rsp_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        bit ok;
        int edges;
        doReset();
        bus1.a_x = 16'h1234; bus1.a_y = 16'h1111; bus1.a_valid = 1'b1; bus1.rsp_ready = 1'b0;
        #1;
        waitResp1(1'b1, ok, edges);
        checks++; if (!ok) begin fails++; $display("[TB] FAIL bp_response got none expected rsp_valid=1"); end
        bus1.a_valid = 1'b1; bus1.b_valid = 1'b1; bus1.a_x = 16'h0f0f; bus1.b_x = 16'h7777;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            checks++; if (bus1.rsp_valid !== 1'b1 || bus1.rsp_z !== 16'h2345 || bus1.rsp_id !== 1'b0) begin fails++; $display("[TB] FAIL bp_hold%0d got valid=%b z=%h id=%b expected 1/2345/0", i, bus1.rsp_valid, bus1.rsp_z, bus1.rsp_id); end
            checks++; if (bus1.a_ready !== 1'b0 || bus1.b_ready !== 1'b0 || bus1.busy !== 1'b1) begin fails++; $display("[TB] FAIL bp_stall%0d got a=%b b=%b busy=%b expected 0/0/1", i, bus1.a_ready, bus1.b_ready, bus1.busy); end
        end
        bus1.a_valid = 1'b0; bus1.b_valid = 1'b0; bus1.rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus1.rsp_valid !== 1'b0 || bus1.busy !== 1'b0) begin fails++; $display("[TB] FAIL bp_release got valid=%b busy=%b expected 0/0", bus1.rsp_valid, bus1.busy); end
        bus1.rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_exec();
        bit ok;
        int edges;
        bit seen;
        doReset();
        bus1.a_x = 16'h0101; bus1.a_y = 16'h0202; bus1.a_valid = 1'b1; bus1.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus1.a_valid = 1'b0;
        checks++; if (bus1.busy !== 1'b1) begin fails++; $display("[TB] FAIL midrst_in_exec got busy=%b expected 1", bus1.busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus1.busy !== 1'b0 || bus1.rsp_valid !== 1'b0 || bus1.alu_x !== 16'd0 || bus1.alu_y !== 16'd0) begin fails++; $display("[TB] FAIL midrst_async got busy=%b valid=%b x=%h y=%h expected 0/0/0000/0000", bus1.busy, bus1.rsp_valid, bus1.alu_x, bus1.alu_y); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus1.rsp_valid !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen) begin fails++; $display("[TB] FAIL midrst_no_rsp got rsp_valid=1 expected 0"); end
        bus1.a_valid = 1'b1; bus1.b_valid = 1'b1;
        #1;
        checks++; if (bus1.a_ready !== 1'b1 || bus1.b_ready !== 1'b0) begin fails++; $display("[TB] FAIL midrst_tie got a=%b b=%b expected a=1 b=0", bus1.a_ready, bus1.b_ready); end
        waitResp1(1'b1, ok, edges);
        @(negedge clk);
        bus1.rsp_ready = 1'b0;
    endtask

    task automatic test_settle();
        int edges;
        bit done;
        doReset();
        alu4Z = 16'h1111; alu4Flags = 5'b00001;
        bus4.a_x = 16'h0001; bus4.a_y = 16'h0002; bus4.a_valid = 1'b1; bus4.rsp_ready = 1'b1;
        #1;
        checks++; if (bus4.a_ready !== 1'b1) begin fails++; $display("[TB] FAIL settle_ready got %b expected 1", bus4.a_ready); end
        edges = 0;
        done = 1'b0;
        while (!done && edges < 64) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (edges == 1) bus4.a_valid = 1'b0;
            if (edges == 2) begin alu4Z = 16'hbeef; alu4Flags = 5'b10100; end
            if (bus4.rsp_valid === 1'b1) done = 1'b1;
        end
        checks++; if (!done || edges != 5) begin fails++; $display("[TB] FAIL settle_latency got %0d edges (done=%0b) expected 5", edges, done); end
        checks++; if (bus4.rsp_z !== 16'hbeef || bus4.rsp_flags !== 5'b10100 || bus4.rsp_id !== 1'b0) begin fails++; $display("[TB] FAIL settle_capture got z=%h f=%b id=%b expected beef/10100/0", bus4.rsp_z, bus4.rsp_flags, bus4.rsp_id); end
        @(negedge clk);
        bus4.rsp_ready = 1'b0;
    endtask

    task automatic test_random();
        bit lastB;
        bit av, bv, expB, done;
        int waitCyc;
        logic [15:0] ax, ay, bx, by;
        logic [20:0] exp;
        doReset();
        lastB = 1'b1;
        for (int n = 0; n < 40; n++) begin
            do begin
                av = 1'($urandom_range(0, 1));
                bv = 1'($urandom_range(0, 1));
            end while (!(av || bv));
            ax = 16'($urandom); ay = 16'($urandom); bx = 16'($urandom); by = 16'($urandom);
            bus1.a_valid = av; bus1.b_valid = bv;
            bus1.a_x = ax; bus1.a_y = ay; bus1.b_x = bx; bus1.b_y = by;
            bus1.rsp_ready = 1'b0;
            #1;
            expB = bv && (!av || !lastB);
            lastB = expB;
            exp = expB ? refAdd(bx, by) : refAdd(ax, ay);
            checks++; if (bus1.a_ready !== !expB || bus1.b_ready !== expB) begin fails++; $display("[TB] FAIL rand_grant%0d got a=%b b=%b expected a=%b b=%b", n, bus1.a_ready, bus1.b_ready, !expB, expB); end
            done = 1'b0;
            waitCyc = 0;
            while (!done && waitCyc < 64) begin
                @(posedge clk);
                waitCyc++;
                @(negedge clk);
                bus1.a_valid = 1'($urandom_range(0, 1)); bus1.b_valid = 1'($urandom_range(0, 1));
                bus1.a_x = 16'($urandom); bus1.b_y = 16'($urandom);
                if (bus1.rsp_valid === 1'b1) done = 1'b1;
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            checks++; if (!done || bus1.rsp_id !== expB || bus1.rsp_z !== exp[15:0] || bus1.rsp_flags !== exp[20:16]) begin fails++; $display("[TB] FAIL rand_result%0d got done=%0b id=%b z=%h f=%b expected id=%b z=%h f=%b", n, done, bus1.rsp_id, bus1.rsp_z, bus1.rsp_flags, expB, exp[15:0], exp[20:16]); end
            bus1.rsp_ready = 1'b1;
            @(negedge clk);
        end
        bus1.a_valid = 1'b0; bus1.b_valid = 1'b0; bus1.rsp_ready = 1'b0;
        @(negedge clk);
    endtask

`ifdef ALU_ARB_STATS_EN
    task automatic test_stats();
        bit ok;
        int edges;
        doReset();
        for (int i = 0; i < 3; i++) runOne1(1'b0, 16'(i), 16'd5, ok);
        for (int i = 0; i < 2; i++) runOne1(1'b1, 16'(i), 16'd9, ok);
        checks++; if (bus1.a_grants !== 16'd3 || bus1.b_grants !== 16'd2) begin fails++; $display("[TB] FAIL stats_count got a=%0d b=%0d expected 3/2", bus1.a_grants, bus1.b_grants); end
        bus1.a_valid = 1'b1; bus1.a_x = 16'd1; bus1.a_y = 16'd1; bus1.stats_clr = 1'b1; bus1.rsp_ready = 1'b1;
        #1;
        checks++; if (bus1.a_ready !== 1'b1) begin fails++; $display("[TB] FAIL stats_clr_grant got a_ready=%b expected 1", bus1.a_ready); end
        @(posedge clk);
        @(negedge clk);
        bus1.stats_clr = 1'b0; bus1.a_valid = 1'b0;
        checks++; if (bus1.a_grants !== 16'd0 || bus1.b_grants !== 16'd0) begin fails++; $display("[TB] FAIL stats_clr got a=%0d b=%0d expected 0/0", bus1.a_grants, bus1.b_grants); end
        waitResp1(1'b0, ok, edges);
        @(negedge clk);
        bus1.rsp_ready = 1'b0;
    endtask
`endif

    // Hard time limit so the bench can never hang
    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired at %0t expected completion earlier", $time);
        $fatal(1, "[TB] watchdog");
    end

    // Test sequence
    initial begin
        idleInputs();
        test_reset();
        test_single_a();
        test_round_robin();
        test_backpressure();
        test_reset_mid_exec();
        test_settle();
        test_random();
`ifdef ALU_ARB_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one external 16-bit ALU (operands X/Y; result Z; flags CY, S, ZR, P, V) between two requesters, A and B.
- Round-robin arbitration; valid/ready handshake on each request port and on the single response port.
- Registers operands into the ALU, waits a programmable settle time, then captures Z and the flags into a held response tagged with the requester id.
- Sits between the requesting units and the shared ALU instance.

Parameters:
- DATA_W, 16: operand/result width; must match the ALU.
- SETTLE_CYC, 1: cycles spent in EXEC before capturing ALU outputs; legal range 1..15.

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- a_valid  in  1  requester A has an operation
- a_ready  out  1  A accepted this cycle
- a_x, a_y  in  DATA_W each  A operands
- b_valid  in  1  requester B has an operation
- b_ready  out  1  B accepted this cycle
- b_x, b_y  in  DATA_W each  B operands
- alu_x, alu_y  out  DATA_W each  registered operands to the ALU
- alu_z  in  DATA_W  ALU result
- alu_cy, alu_s, alu_zr, alu_p, alu_v  in  1 each  ALU flags
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response
- rsp_id  out  1  0 = A, 1 = B
- rsp_z  out  DATA_W  captured result
- rsp_flags  out  5  {V,P,ZR,S,CY}, captured
- busy  out  1  state != IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE; alu_x=alu_y=0; rsp_valid=0; rsp_id=0; rsp_z=0; rsp_flags=0; last_grant=1 (B), so A wins the first tie; settle counter=0. In-flight operation is dropped; no response emitted.
- States: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - If any valid, grant: only one valid -> that one; both valid -> the one not equal to last_grant.
  - a_ready/b_ready are combinational: high only in IDLE for the granted requester; at most one high per cycle.
  - On grant: latch operands into alu_x/alu_y, record id, update last_grant, load counter=SETTLE_CYC-1, go to EXEC.
  - No valid -> stay.
- EXEC:
  - Counter decrements each cycle.
  - When counter==0: capture alu_z and flags into rsp_z/rsp_flags, set rsp_valid=1, go to RESP.
  - Grant to rsp_valid latency = SETTLE_CYC+1 edges.
- RESP:
  - rsp_valid, rsp_id, rsp_z and rsp_flags held stable until rsp_ready=1 at a clock edge; then rsp_valid=0, go to IDLE.
  - No new accept in the same cycle as response retirement.
  - Max throughput is one op per SETTLE_CYC+2 cycles.
- Requests: valid may deassert before acceptance without effect. Operands are sampled only on the accepting edge. Requests arriving outside IDLE wait; ready stays low.
- alu_x/alu_y hold their last value outside EXEC.
- Flags pass through unmodified; the arbiter performs no arithmetic.

Optional Feature:
- Macro ALU_ARB_STATS_EN.
- Defined:
  - Adds outputs a_grants and b_grants (16-bit each).
  - Each increments on its requester's accept and wraps 0xFFFF->0x0000.
  - Both reset to 0.
  - Adds input stats_clr (1): synchronous clear of both counters; clear wins over a same-cycle increment.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset then A only, a_x=8fff, a_y=8000, bench ALU = adder, SETTLE_CYC=1, rsp_ready=1 -> a_ready 1 cycle; rsp_valid 2 edges later; rsp_id=0, rsp_z=0fff, CY=1, S=0, ZR=0, V=1.
- A and B valid together for 4 ops (A: fffe+8002, B: aaaa+5555) -> grant order A,B,A,B; A rsp_z=8000, CY=1, S=1, V=0; B rsp_z=ffff, S=1, CY=0, ZR=0, V=0.
- rsp_ready held low 10 cycles in RESP -> rsp_valid and rsp_z stable; a_ready/b_ready stay 0; busy=1.
- rst_n asserted mid-EXEC -> all outputs return to reset values immediately; no response after release; next tie goes to A.
- SETTLE_CYC=4; ALU output changes at EXEC cycle 2 -> value present at cycle 4 is captured; latency 5 edges.
- ALU_ARB_STATS_EN: 3 A and 2 B grants -> a_grants=3, b_grants=2; stats_clr pulsed together with an A grant -> both counters 0.
